// File: rtl/stream_fifo_v2.sv
// stream_fifo_v2: synchronous FIFO with req/ack streaming handshakes,
// occupancy count, almost-full/almost-empty flags, peak-occupancy tracking
// and sticky overflow/underflow flags. DEPTH need not be a power of two.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where the request and the
//   acknowledge are both high. The request (req_in / req_out) never depends
//   on the matching acknowledge. ack_in and req_out depend only on
//   registered state and flush, so the FIFO has no combinational path from
//   the consumer to the producer. When the FIFO is full, a pop does not free
//   a slot until the following cycle. A flush cycle transfers nothing.
module stream_fifo_v2 #(
  parameter  int DW     = 8,
  parameter  int DEPTH  = 7,
  parameter  int AF_LVL = DEPTH - 1,
  parameter  int AE_LVL = 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] d_in,
  input  logic          req_in,
  output logic          ack_in,
  output logic [DW-1:0] d_out,
  output logic          req_out,
  input  logic          ack_out,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] peak,
  input  logic          clr_peak,
  output logic          ovf,
  output logic          udf
);

  // Pointer width: DEPTH >= 2, so at least one bit.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);

  // Storage and state registers
  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_peak;
  logic          r_ovf;
  logic          r_udf;

  // Combinational helpers
  logic          w_full;
  logic          w_empty;
  logic          w_ack_in;
  logic          w_req_out;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_ptr_inc;
  logic [PW-1:0] w_rd_ptr_inc;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_peak_nxt;
  logic          w_ovf_evt;
  logic          w_udf_evt;

  // Handshake decode from registered occupancy and flush only
  always_comb begin
    w_full    = (r_count == FULL_CNT);
    w_empty   = (r_count == '0);
    w_ack_in  = ~w_full & ~flush;
    w_req_out = ~w_empty & ~flush;
    w_push    = req_in & w_ack_in;
    w_pop     = ack_out & w_req_out;
    // Refused requests outside a flush cycle are protocol errors.
    w_ovf_evt = req_in & ~w_ack_in & ~flush;
    w_udf_evt = ack_out & ~w_req_out & ~flush;
  end

  // Pointer increment with explicit wrap so any DEPTH works
  always_comb begin
    w_wr_ptr_inc = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PW'(1);
    w_rd_ptr_inc = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PW'(1);
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = w_wr_ptr_inc;
      if (w_pop)  w_rd_ptr_nxt = w_rd_ptr_inc;
    end
  end

  // Next occupancy: +1 push only, -1 pop only, flush empties the queue
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next peak: clr_peak restarts tracking from the next occupancy
  always_comb begin
    w_peak_nxt = r_peak;
    if (clr_peak) begin
      w_peak_nxt = w_count_nxt;
    end else if (w_count_nxt > r_peak) begin
      w_peak_nxt = w_count_nxt;
    end
  end

  // Storage write; contents are never cleared, only pointers are
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= d_in;
    end
  end

  // Control state register; rst overrides everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_peak   <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_peak   <= w_peak_nxt;
      if (w_ovf_evt) r_ovf <= 1'b1;
      if (w_udf_evt) r_udf <= 1'b1;
    end
  end

  // Outputs: all derived from registered state (plus flush on handshakes)
  always_comb begin
    ack_in       = w_ack_in;
    req_out      = w_req_out;
    d_out        = r_mem[r_rd_ptr];
    count        = r_count;
    almost_full  = (r_count >= AF_CNT);
    almost_empty = (r_count <= AE_CNT);
    peak         = r_peak;
    ovf          = r_ovf;
    udf          = r_udf;
  end

endmodule
